// File: rtl/dut_seq_trojan.sv
// Pipelined mode-selected arithmetic on the two halves of the input word, with an
// embedded sequential trojan that arms after a run of trigger vectors.
module dut_seq_trojan #(
   parameter int          WIDTH         = 32,
   parameter int          STAGES        = 2,
   parameter logic [31:0] TRIGGER_VALUE = 32'hDEADBEEF,
   parameter int          TRIGGER_COUNT = 3,
   parameter int          HOLD          = 4,
   parameter logic [31:0] PAYLOAD_MASK  = 32'h0000_0100,
   parameter bit          TROJAN_EN     = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dut_input,
   input  logic             dut_input_valid,
   input  logic [1:0]       dut_mode,
   input  logic [31:0]      dut_signal_select,
   output logic             dut_output,
   output logic [WIDTH-1:0] dut_result,
   output logic             dut_output_valid
);

   localparam int H     = WIDTH / 2;
   localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] TRIG  = WIDTH'(TRIGGER_VALUE);
   localparam logic [WIDTH-1:0] PMASK = WIDTH'(PAYLOAD_MASK);

   typedef enum logic [1:0] {IDLE, COUNTING, ARMED} state_t;

   state_t      state_q, state_d;
   logic [31:0] match_q, match_d;
   logic [31:0] hold_q, hold_d;
   logic        trig_hit;
   logic        armed_now;

   logic             vld_p0;
   logic [WIDTH-1:0] op_p0;
   logic [1:0]       mode_p0;
   logic             pay_p0;
   logic [WIDTH-1:0] res_p1;
   logic [WIDTH-1:0] res_pn [STAGES];
   logic [STAGES-1:0] vld_pn;

   function automatic logic [WIDTH-1:0] compute(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       m);
      logic [H-1:0] a, b, diff;
      logic [H:0]   sum;
      a    = v[WIDTH-1:H];
      b    = v[H-1:0];
      sum  = {1'b0, a} + {1'b0, b};
      diff = a - b;
      case (m)
         2'd0:    compute = WIDTH'(sum);
         2'd1:    compute = WIDTH'(diff);
         2'd2:    compute = WIDTH'(a ^ b);
         default: compute = v;
      endcase
   endfunction

   assign trig_hit  = (dut_input == TRIG);
   assign armed_now = TROJAN_EN && (state_q == ARMED);

   // Trojan state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         match_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      match_d = match_q;
      hold_d  = hold_q;
      if (TROJAN_EN && dut_input_valid) begin
         case (state_q)
            IDLE: begin
               if (trig_hit) begin
                  match_d = 32'd1;
                  state_d = (TRIGGER_COUNT == 1) ? ARMED : COUNTING;
               end
            end
            COUNTING: begin
               if (trig_hit) begin
                  match_d = match_q + 32'd1;
                  if (match_q + 32'd1 == 32'(TRIGGER_COUNT)) state_d = ARMED;
               end else begin
                  state_d = IDLE;
                  match_d = '0;
               end
            end
            ARMED: begin
               // Matches here are ordinary victims; only the hold count advances.
               hold_d = hold_q + 32'd1;
               if (HOLD != 0 && hold_q + 32'd1 == 32'(HOLD)) begin
                  state_d = IDLE;
                  match_d = '0;
                  hold_d  = '0;
               end
            end
            default: begin
               state_d = IDLE;
               match_d = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   // Stage 1: arithmetic plus payload decided at acceptance time
   assign res_p1 = compute(op_p0, mode_p0) ^ (pay_p0 ? PMASK : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0  <= 1'b0;
         op_p0   <= '0;
         mode_p0 <= '0;
         pay_p0  <= 1'b0;
         vld_pn  <= '0;
         for (int i = 0; i < STAGES; i++) res_pn[i] <= '0;
      end else begin
         // Stage 0: operand capture
         vld_p0 <= dut_input_valid;
         if (dut_input_valid) begin
            op_p0   <= dut_input;
            mode_p0 <= dut_mode;
            pay_p0  <= armed_now;
         end
         vld_pn[0] <= vld_p0;
         if (vld_p0) res_pn[0] <= res_p1;
         // Later stages only move on valid, so the last stage holds between pulses
         for (int i = 1; i < STAGES; i++) begin
            vld_pn[i] <= vld_pn[i-1];
            if (vld_pn[i-1]) res_pn[i] <= res_pn[i-1];
         end
      end
   end

   assign dut_result       = res_pn[STAGES-1];
   assign dut_output_valid = vld_pn[STAGES-1];
   assign dut_output       = (dut_signal_select < 32'(WIDTH)) ?
                             dut_result[dut_signal_select[SEL_W-1:0]] : 1'b0;

endmodule

// File: tb/tb_dut_seq_trojan.sv
// Randomised bench for dut_seq_trojan: default, trojan-free and endless-hold builds
// driven in parallel and compared against a time-keyed scoreboard model.
module tb_dut_seq_trojan;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] dut_input = '0;
   logic        dut_input_valid = 1'b0;
   logic [1:0]  dut_mode = '0;
   logic [31:0] dut_signal_select = '0;

   logic [31:0] r_res [3];
   logic        r_vld [3];
   logic        r_out [3];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dut_seq_trojan u_dut (
      .clk(clk), .reset(reset), .dut_input(dut_input), .dut_input_valid(dut_input_valid),
      .dut_mode(dut_mode), .dut_signal_select(dut_signal_select),
      .dut_output(r_out[0]), .dut_result(r_res[0]), .dut_output_valid(r_vld[0]));

   dut_seq_trojan #(.TROJAN_EN(1'b0)) u_clean (
      .clk(clk), .reset(reset), .dut_input(dut_input), .dut_input_valid(dut_input_valid),
      .dut_mode(dut_mode), .dut_signal_select(dut_signal_select),
      .dut_output(r_out[1]), .dut_result(r_res[1]), .dut_output_valid(r_vld[1]));

   dut_seq_trojan #(.HOLD(0)) u_hold0 (
      .clk(clk), .reset(reset), .dut_input(dut_input), .dut_input_valid(dut_input_valid),
      .dut_mode(dut_mode), .dut_signal_select(dut_signal_select),
      .dut_output(r_out[2]), .dut_result(r_res[2]), .dut_output_valid(r_vld[2]));

   // Reference model: per build, a run length of trigger hits and a remaining-victims budget
   bit          m_en   [3] = '{1'b1, 1'b0, 1'b1};
   int          m_hold [3] = '{4, 4, 0};
   bit          m_armed[3];
   int          m_run  [3];
   int          m_left [3];
   bit          due_v  [3][8];
   logic [31:0] due_r  [3][8];
   logic [31:0] m_last [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] clean_op(input logic [31:0] d, input logic [1:0] m);
      int a, b;
      a = int'(d >> 16);
      b = int'(d & 32'hFFFF);
      case (m)
         2'd0:    return 32'(a + b);
         2'd1:    return 32'((a - b) & 32'hFFFF);
         2'd2:    return 32'(a ^ b);
         default: return d;
      endcase
   endfunction

   task automatic model_edge(input bit r, input bit v, input logic [31:0] d, input logic [1:0] m);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            m_armed[k] = 1'b0;
            m_run[k]   = 0;
            m_left[k]  = 0;
            m_last[k]  = '0;
            for (int s = 0; s < 8; s++) due_v[k][s] = 1'b0;
         end else if (v) begin
            due_v[k][(cyc + LAT) % 8] = 1'b1;
            due_r[k][(cyc + LAT) % 8] = clean_op(d, m) ^ (m_armed[k] ? 32'h100 : 32'h0);
            if (m_en[k]) begin
               if (m_armed[k]) begin
                  if (m_hold[k] != 0) begin
                     m_left[k]--;
                     if (m_left[k] == 0) m_armed[k] = 1'b0;
                  end
               end else begin
                  m_run[k] = (d == 32'hDEADBEEF) ? m_run[k] + 1 : 0;
                  if (m_run[k] == 3) begin
                     m_armed[k] = 1'b1;
                     m_left[k]  = m_hold[k];
                     m_run[k]   = 0;
                  end
               end
            end
         end
      end
   endtask

   task automatic check_outputs();
      bit          ev;
      logic [31:0] sel;
      sel = dut_signal_select;
      for (int k = 0; k < 3; k++) begin
         ev = due_v[k][cyc % 8];
         if (ev) begin
            m_last[k] = due_r[k][cyc % 8];
            due_v[k][cyc % 8] = 1'b0;
         end
         chk($sformatf("vld%0d", k), 32'(r_vld[k]), 32'(ev));
         chk($sformatf("res%0d", k), r_res[k], m_last[k]);
         chk($sformatf("out%0d_sel%0d", k, sel), 32'(r_out[k]),
             (sel < 32) ? 32'((m_last[k] >> sel) & 32'h1) : 32'h0);
      end
   endtask

   task automatic cycle(input bit r, input bit v, input logic [31:0] d, input logic [1:0] m);
      @(negedge clk);
      reset             = r;
      dut_input_valid   = v;
      dut_input         = d;
      dut_mode          = m;
      dut_signal_select = $urandom_range(0, 40);
      @(posedge clk);
      cyc++;
      model_edge(r, v, d, m);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, 2'(($urandom)));
   endtask

   initial begin
      logic [31:0] d;
      cycle(1'b1, 1'b0, '0, 2'd0);
      cycle(1'b1, 1'b0, '0, 2'd0);
      idle(2);
      // Single add, then the three other modes back-to-back with an add
      cycle(1'b0, 1'b1, 32'h0003_0005, 2'd0);
      idle(3);
      for (int m = 1; m <= 4; m++) cycle(1'b0, 1'b1, 32'h0001_0002, 2'(m));
      idle(3);
      // Arm with gapped trigger vectors, then five victims
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 32'hDEADBEEF, 2'd0);
         idle(1);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h0003_0005, 2'd0);
      idle(3);
      // Broken trigger run
      cycle(1'b0, 1'b1, 32'hDEADBEEF, 2'd0);
      cycle(1'b0, 1'b1, 32'hDEADBEEF, 2'd0);
      cycle(1'b0, 1'b1, 32'h0000_0000, 2'd0);
      cycle(1'b0, 1'b1, 32'hDEADBEEF, 2'd0);
      cycle(1'b0, 1'b1, 32'h0003_0005, 2'd0);
      idle(3);
      // Arm, then reset with two ops in flight
      cycle(1'b1, 1'b0, '0, 2'd0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hDEADBEEF, 2'd0);
      cycle(1'b0, 1'b1, 32'h0003_0005, 2'd0);
      cycle(1'b0, 1'b1, 32'h0003_0005, 2'd0);
      cycle(1'b1, 1'b0, '0, 2'd0);
      cycle(1'b0, 1'b1, 32'h0003_0005, 2'd0);
      idle(3);
      // Random traffic with frequent triggers and rare resets
      for (int i = 0; i < 600; i++) begin
         d = ($urandom_range(0, 3) == 0) ? 32'hDEADBEEF : 32'($urandom);
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), d,
               2'($urandom_range(0, 3)));
      end
      idle(4);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
